// File: rtl/bcd_indicator_scan.sv
// Purpose : time-multiplexed driver for a 5-digit common-anode 7-segment
//           indicator fed with an 18-bit BCD8421 word (0..16383).
// Latency : AN/SEG/FRAME are registered one cycle after the slot state that
//           produces them; a loaded value appears from the next frame start
//           (worst case 5*CLK_DIV cycles).
// Backpressure: none; LOAD is accepted every cycle and the last one before a
//           frame start wins.
//
// Ports:
//   CLK    system clock
//   RST    synchronous reset, active-high
//   BCD    [17:16] ten-thousands, [15:12] thousands, [11:8] hundreds,
//          [7:4] tens, [3:0] units
//   LOAD   one-cycle strobe, BCD sampled when high
//   SEG    segments {g,f,e,d,c,b,a}, active-low
//   AN     digit anodes, active-low, AN[0]=units .. AN[4]=ten-thousands
//   FRAME  one-cycle pulse at the start of every frame
//
// Optional: define INDICATOR_LZB_EN for leading-zero blanking of digits 4..1.

module bcd_indicator_scan #(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [17:0] BCD,
  input  logic        LOAD,
  output logic [6:0]  SEG,
  output logic [4:0]  AN,
  output logic        FRAME
);

  localparam int CW = $clog2(CLK_DIV);

  typedef enum logic {
    ST_GAP  = 1'b0,
    ST_SHOW = 1'b1
  } state_e;

  // Counter restarts at 0 after reset, so the slot state must match that.
  localparam state_e ST_RST = (BLANK_CYC > 0) ? ST_GAP : ST_SHOW;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [17:0]   pend_q, pend_d;
  logic          pflag_q, pflag_d;
  logic [17:0]   disp_q, disp_d;
  state_e        state_q, state_d;
  logic [6:0]    seg_q, seg_d;
  logic [4:0]    an_q, an_d;
  logic          frame_q, frame_d;

  logic          frame_start;
  logic [3:0]    nib;
  logic          suppress;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;  // non-decimal nibble shows a dash
    endcase
    return s;
  endfunction

  // Slot counter, digit index, pending/display handoff.
  always_comb begin
    frame_start = (cnt_q == '0) && (idx_q == 3'd0);
    cnt_d       = cnt_q + 1'b1;
    idx_d       = idx_q;
    if (cnt_q == CW'(CLK_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
    end

    pend_d  = pend_q;
    pflag_d = pflag_q;
    disp_d  = disp_q;
    // Display swap happens only here, so a frame never mixes two values.
    if (frame_start && pflag_q) begin
      disp_d  = pend_q;
      pflag_d = 1'b0;
    end
    // A load on the frame-start cycle lands in pending and stays flagged;
    // the display has already taken the previous pending value above.
    if (LOAD) begin
      pend_d  = BCD;
      pflag_d = 1'b1;
    end

    // State tracks the counter value it will hold next cycle.
    state_d = (32'(cnt_d) < 32'(BLANK_CYC)) ? ST_GAP : ST_SHOW;
    frame_d = frame_start;
  end

  // Digit select reads disp_d so that with no blanking gap the first
  // on-cycle of a frame already shows the newly swapped value.
  always_comb begin
    case (idx_q)
      3'd0:    nib = disp_d[3:0];
      3'd1:    nib = disp_d[7:4];
      3'd2:    nib = disp_d[11:8];
      3'd3:    nib = disp_d[15:12];
      3'd4:    nib = {2'b00, disp_d[17:16]};
      default: nib = 4'h0;
    endcase
  end

`ifdef INDICATOR_LZB_EN
  // lz[k]: digit k and every higher digit are zero (nibble >9 is non-zero).
  logic [4:1] lz;
  always_comb begin
    lz[4] = (disp_d[17:16] == 2'b00);
    lz[3] = lz[4] && (disp_d[15:12] == 4'h0);
    lz[2] = lz[3] && (disp_d[11:8]  == 4'h0);
    lz[1] = lz[2] && (disp_d[7:4]   == 4'h0);
  end

  always_comb begin
    case (idx_q)
      3'd1:    suppress = lz[1];
      3'd2:    suppress = lz[2];
      3'd3:    suppress = lz[3];
      3'd4:    suppress = lz[4];
      default: suppress = 1'b0;  // units digit is always shown
    endcase
  end
`else
  assign suppress = 1'b0;
`endif

  // Output decode for the current slot state; registered below.
  always_comb begin
    seg_d = 7'h7F;
    an_d  = 5'b11111;
    if ((state_q == ST_SHOW) && !suppress) begin
      an_d  = ~(5'b00001 << idx_q);
      seg_d = seg_decode(nib);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      pend_q  <= 18'd0;
      pflag_q <= 1'b0;
      disp_q  <= 18'd0;
      state_q <= ST_RST;
      seg_q   <= 7'h7F;
      an_q    <= 5'b11111;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      pflag_q <= pflag_d;
      disp_q  <= disp_d;
      state_q <= state_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      frame_q <= frame_d;
    end
  end

  assign SEG   = seg_q;
  assign AN    = an_q;
  assign FRAME = frame_q;

endmodule

// File: tb/tb_bcd_indicator_scan.sv
// Bench for bcd_indicator_scan with CLK_DIV=4, BLANK_CYC=1 (20-cycle frame).
// Stimulus pushes one expected frame per FRAME pulse; a monitor pops it on
// each FRAME and checks every slot cycle of that frame.

module tb_bcd_indicator_scan;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [17:0] BCD = 18'd0;
  logic        LOAD = 1'b0;
  logic [6:0]  SEG;
  logic [4:0]  AN;
  logic        FRAME;

  always #5 CLK = ~CLK;

  bcd_indicator_scan #(.CLK_DIV(4), .BLANK_CYC(1)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .BCD   (BCD),
    .LOAD  (LOAD),
    .SEG   (SEG),
    .AN    (AN),
    .FRAME (FRAME)
  );

  typedef struct {
    logic [4:0][6:0] seg;   // expected code per digit, [4]=ten-thousands
    logic [4:0]      act;   // digits whose anode is driven in SHOW
    int              len;   // cycles of the frame to check
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int frames_done = 0;
  int t = 0;

  function automatic exp_t mk(input logic [4:0][6:0] s, input logic [4:0] a_full,
                              input logic [4:0] a_lzb, input int len);
    exp_t e;
    e.seg = s;
`ifdef INDICATOR_LZB_EN
    e.act = a_lzb;
`else
    e.act = a_full;
`endif
    e.len = len;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Advance to just after the rising edge that starts cycle n.
  task automatic go(input int n);
    repeat (n - t) @(posedge CLK);
    #1;
    t = n;
  endtask

  task automatic do_load(input int at, input logic [17:0] v);
    go(at);
    BCD  = v;
    LOAD = 1'b1;
    go(at + 1);
    LOAD = 1'b0;
  endtask

  // Monitor
  exp_t       m_e;
  bit         m_ok;
  logic [4:0] m_an;
  logic [6:0] m_seg;
  int         m_k;

  initial begin
    forever begin
      @(negedge CLK);
      if (FRAME === 1'b1) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL frame_unexpected: got FRAME pulse, want none queued");
        end else begin
          m_e  = q.pop_front();
          m_ok = 1'b1;
          for (int j = 0; j < m_e.len; j++) begin
            if (j > 0) @(negedge CLK);
            m_k = j / 4;
            if ((j % 4) >= 1 && m_e.act[m_k]) begin
              m_an  = ~(5'b00001 << m_k);
              m_seg = m_e.seg[m_k];
            end else begin
              m_an  = 5'b11111;
              m_seg = 7'h7F;
            end
            if (m_ok && (AN !== m_an || SEG !== m_seg || FRAME !== (j == 0))) begin
              m_ok = 1'b0;
              $display("FAIL frame%0d cyc%0d: got AN=%b SEG=%h FRAME=%b, want AN=%b SEG=%h FRAME=%b",
                       frames_done, j, AN, SEG, FRAME, m_an, m_seg, (j == 0));
            end
          end
          if (!m_ok) fails++;
          frames_done++;
        end
      end
    end
  end

  // Stimulus
  initial begin
    // Frame 0: display 00000
    q.push_back(mk({7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 5'b11111, 5'b00001, 20));

    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      check("rst_seg", 32'(SEG), 32'h7F);
      check("rst_an", 32'(AN), 32'h1F);
      check("rst_frame", 32'(FRAME), 32'h0);
    end
    RST = 1'b0;
    t = 0;
    check("frame_not_at_release", 32'(FRAME), 32'h0);
    go(1);
    @(negedge CLK);
    check("frame_one_after_release", 32'(FRAME), 32'h1);

    // Frame 1: 16383
    do_load(5, 18'h16383);
    q.push_back(mk({7'h79, 7'h02, 7'h30, 7'h00, 7'h30}, 5'b11111, 5'b11111, 20));

    // Frame 2: back-to-back loads, last one (7) wins
    do_load(25, 18'h00005);
    do_load(26, 18'h00007);
    q.push_back(mk({7'h40, 7'h40, 7'h40, 7'h40, 7'h78}, 5'b11111, 5'b00001, 20));

    // Frame 3 shows 42; load on the visible FRAME cycle goes to frame 4
    do_load(50, 18'h00042);
    q.push_back(mk({7'h40, 7'h40, 7'h40, 7'h19, 7'h24}, 5'b11111, 5'b00011, 20));
    do_load(61, 18'h000A2);
    q.push_back(mk({7'h40, 7'h40, 7'h40, 7'h3F, 7'h24}, 5'b11111, 5'b00011, 20));

    // Frame 5 shows 9; load on the internal frame-start cycle goes to frame 6
    do_load(90, 18'h00009);
    q.push_back(mk({7'h40, 7'h40, 7'h40, 7'h40, 7'h10}, 5'b11111, 5'b00001, 20));
    do_load(100, 18'h00000);
    q.push_back(mk({7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 5'b11111, 5'b00001, 20));
    // Frame 7 cut short by reset after 10 cycles
    q.push_back(mk({7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 5'b11111, 5'b00001, 10));

    // Pending value lost to mid-frame reset
    do_load(145, 18'h00123);
    go(150);
    RST = 1'b1;
    // Frame 8: first frame after reset shows 00000
    q.push_back(mk({7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 5'b11111, 5'b00001, 20));
    go(151);
    @(negedge CLK);
    check("midrst_seg", 32'(SEG), 32'h7F);
    check("midrst_an", 32'(AN), 32'h1F);
    check("midrst_frame", 32'(FRAME), 32'h0);
    go(152);
    go(153);
    RST = 1'b0;

    for (int i = 0; i < 200 && frames_done < 9; i++) @(posedge CLK);
    check("frames_checked", 32'(frames_done), 32'd9);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
